// File: rtl/simple_ram.sv
// Byte-maskable register-file RAM: one registered read port, one strobed write port,
// asynchronous clear of every word and of the read register.
module simple_ram #(
    parameter int NUM_SLOTS        = 5,
    parameter int DATA_WIDTH_BYTES = 4,
    localparam int DATA_WIDTH_BITS = DATA_WIDTH_BYTES * 8,
    localparam int ADDR_WIDTH_BITS = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        r_en,
    input  logic [ADDR_WIDTH_BITS-1:0]  r_addr,
    output logic [DATA_WIDTH_BITS-1:0]  r_data,
    input  logic                        w_en,
    input  logic [ADDR_WIDTH_BITS-1:0]  w_addr,
    input  logic [DATA_WIDTH_BITS-1:0]  w_data,
    input  logic [DATA_WIDTH_BYTES-1:0] w_strb
);

    // Slot count widened by one bit so addresses up to 2**ADDR_WIDTH_BITS-1 compare cleanly.
    localparam logic [ADDR_WIDTH_BITS:0] SLOT_LIMIT = (ADDR_WIDTH_BITS + 1)'(NUM_SLOTS);

    logic [DATA_WIDTH_BITS-1:0] memory [NUM_SLOTS];

    logic                        r_in_range;
    logic [NUM_SLOTS-1:0]        slot_sel;
    logic [NUM_SLOTS-1:0]        slot_hit;
    logic [DATA_WIDTH_BITS-1:0]  r_word;
    logic [DATA_WIDTH_BITS-1:0]  slot_word [NUM_SLOTS];
    logic [DATA_WIDTH_BITS-1:0]  read_terms [NUM_SLOTS+1];

    assign r_in_range = ({1'b0, r_addr} < SLOT_LIMIT);

    // Address decode per slot; addresses beyond the last slot select nothing.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign slot_sel[gi]  = w_en && (w_addr == ADDR_WIDTH_BITS'(gi));
            assign slot_hit[gi]  = (r_addr == ADDR_WIDTH_BITS'(gi));
            assign slot_word[gi] = slot_hit[gi] ? memory[gi] : '0;
        end
    endgenerate

    // OR-reduce the one-hot masked words to form the read mux.
    assign read_terms[0] = '0;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_read_or
            assign read_terms[gi+1] = read_terms[gi] | slot_word[gi];
        end
    endgenerate
    assign r_word = r_in_range ? read_terms[NUM_SLOTS] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                memory[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                for (int k = 0; k < DATA_WIDTH_BYTES; k++) begin
                    if (slot_sel[s] && w_strb[k]) begin
                        memory[s][8*k +: 8] <= w_data[8*k +: 8];
                    end
                end
            end
        end
    end

    // Sampling the array before this edge's write lands gives read-before-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (r_en) begin
            r_data <= r_word;
        end
    end

endmodule

// File: tb/tb_simple_ram.sv
// Directed bench for simple_ram: reset, strobes, enables, range limits, collisions, streaming.
module tb_simple_ram;

    localparam int NS = 5;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          r_en;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_data;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [31:0]   w_data;
    logic [3:0]    w_strb;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_mem [NS];

    simple_ram dut (
        .clk    (clk),
        .rst    (rst),
        .r_en   (r_en),
        .r_addr (r_addr),
        .r_data (r_data),
        .w_en   (w_en),
        .w_addr (w_addr),
        .w_data (w_data),
        .w_strb (w_strb)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        r_en = 1'b0;
        w_en = 1'b0;
        w_strb = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        r_addr = '0; w_addr = '0; w_data = '0;
        #1;
        for (int i = 0; i < NS; i++) begin
            n_tests++;
            if (dut.memory[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_init_mem[%0d]: got %h expected %h", i, dut.memory[i], 32'h0);
            end
        end
        n_tests++;
        if (r_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_init_rdata: got %h expected %h", r_data, 32'h0);
        end
        // write coincident with reset must be discarded
        w_en = 1'b1; w_addr = 3'd0; w_data = 32'hCAFEF00D; w_strb = 4'hF;
        tick();
        n_tests++;
        if (dut.memory[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_discard_write: got %h expected %h", dut.memory[0], 32'h0);
        end
        idle();
        tick();
        rst = 1'b0;
        w_en = 1'b1; w_addr = 3'd3; w_data = 32'h12345678; w_strb = 4'hF;
        tick();
        idle();
        r_en = 1'b1; r_addr = 3'd3;
        tick();
        idle();
        n_tests++;
        if (r_data !== 32'h12345678) begin
            n_fail++;
            $display("FAIL pre_reset_read: got %h expected %h", r_data, 32'h12345678);
        end
        // assert reset between edges; clear must be immediate
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (dut.memory[3] !== 32'h0 || r_data !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: mem3 %h rdata %h expected 0 and 0", dut.memory[3], r_data);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < NS; i++) begin
            r_en = 1'b1; r_addr = AW'(i);
            tick();
            n_tests++;
            if (r_data !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read[%0d]: got %h expected %h", i, r_data, 32'h0);
            end
        end
        idle();
        for (int i = 0; i < NS; i++) exp_mem[i] = 32'h0;
        $display("[TB] test_reset done");
    endtask

    task automatic test_partial_strobe();
        w_en = 1'b1; w_addr = 3'd0; w_data = 32'h11223344; w_strb = 4'b1101;
        tick();
        idle();
        exp_mem[0] = 32'h11220044;
        n_tests++;
        if (dut.memory[0] !== 32'h11220044) begin
            n_fail++;
            $display("FAIL strobe_mem: got %h expected %h", dut.memory[0], 32'h11220044);
        end
        r_en = 1'b1; r_addr = 3'd0;
        tick();
        idle();
        n_tests++;
        if (r_data !== 32'h11220044) begin
            n_fail++;
            $display("FAIL strobe_read: got %h expected %h", r_data, 32'h11220044);
        end
        // zero strobe with enable is a no-op
        w_en = 1'b1; w_addr = 3'd0; w_data = 32'hFFFFFFFF; w_strb = 4'b0000;
        tick();
        idle();
        n_tests++;
        if (dut.memory[0] !== 32'h11220044) begin
            n_fail++;
            $display("FAIL zero_strobe: got %h expected %h", dut.memory[0], 32'h11220044);
        end
        // single high byte update
        w_en = 1'b1; w_addr = 3'd0; w_data = 32'h99000000; w_strb = 4'b1000;
        tick();
        idle();
        n_tests++;
        if (dut.memory[0] !== 32'h99220044) begin
            n_fail++;
            $display("FAIL high_byte: got %h expected %h", dut.memory[0], 32'h99220044);
        end
        w_en = 1'b1; w_addr = 3'd0; w_data = 32'h11000000; w_strb = 4'b1000;
        tick();
        idle();
        $display("[TB] test_partial_strobe done");
    endtask

    task automatic test_write_disabled();
        w_en = 1'b0; w_addr = 3'd1; w_data = 32'hFFFFFFFF; w_strb = 4'b1111;
        tick();
        idle();
        n_tests++;
        if (dut.memory[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL wen_low_mem: got %h expected %h", dut.memory[1], 32'h0);
        end
        r_en = 1'b1; r_addr = 3'd1;
        tick();
        idle();
        n_tests++;
        if (r_data !== 32'h0) begin
            n_fail++;
            $display("FAIL wen_low_read: got %h expected %h", r_data, 32'h0);
        end
        $display("[TB] test_write_disabled done");
    endtask

    task automatic test_read_hold();
        r_en = 1'b1; r_addr = 3'd0;
        tick();
        r_en = 1'b0; r_addr = 3'd1;
        tick();
        r_addr = 3'd6;
        tick();
        n_tests++;
        if (r_data !== 32'h11220044) begin
            n_fail++;
            $display("FAIL read_hold: got %h expected %h", r_data, 32'h11220044);
        end
        idle();
        $display("[TB] test_read_hold done");
    endtask

    task automatic test_out_of_range();
        w_en = 1'b1; w_addr = 3'd5; w_data = 32'hDEADBEEF; w_strb = 4'hF;
        tick();
        w_addr = 3'd7;
        tick();
        idle();
        for (int i = 0; i < NS; i++) begin
            n_tests++;
            if (dut.memory[i] !== exp_mem[i]) begin
                n_fail++;
                $display("FAIL oor_write_mem[%0d]: got %h expected %h", i, dut.memory[i], exp_mem[i]);
            end
        end
        r_en = 1'b1; r_addr = 3'd6;
        tick();
        idle();
        n_tests++;
        if (r_data !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_read: got %h expected %h", r_data, 32'h0);
        end
        $display("[TB] test_out_of_range done");
    endtask

    task automatic test_collision();
        w_en = 1'b1; w_addr = 3'd2; w_data = 32'hAAAAAAAA; w_strb = 4'hF;
        tick();
        w_data = 32'h55555555;
        r_en = 1'b1; r_addr = 3'd2;
        tick();
        w_en = 1'b0;
        n_tests++;
        if (r_data !== 32'hAAAAAAAA) begin
            n_fail++;
            $display("FAIL collision_old: got %h expected %h", r_data, 32'hAAAAAAAA);
        end
        tick();
        idle();
        exp_mem[2] = 32'h55555555;
        n_tests++;
        if (r_data !== 32'h55555555) begin
            n_fail++;
            $display("FAIL collision_new: got %h expected %h", r_data, 32'h55555555);
        end
        $display("[TB] test_collision done");
    endtask

    task automatic test_back_to_back();
        // Each cycle writes slot i and reads slot i-1, written one cycle earlier.
        logic [31:0] exp_rd;
        for (int i = 0; i < NS; i++) begin
            int ra;
            ra = (i + NS - 1) % NS;
            w_en = 1'b1; w_addr = AW'(i); w_data = 32'hB0B00000 | i; w_strb = 4'hF;
            r_en = 1'b1; r_addr = AW'(ra);
            exp_rd = exp_mem[ra];
            tick();
            exp_mem[i] = 32'hB0B00000 | i;
            n_tests++;
            if (r_data !== exp_rd) begin
                n_fail++;
                $display("FAIL b2b_read[%0d]: got %h expected %h", i, r_data, exp_rd);
            end
        end
        idle();
        for (int i = 0; i < NS; i++) begin
            n_tests++;
            if (dut.memory[i] !== exp_mem[i]) begin
                n_fail++;
                $display("FAIL b2b_mem[%0d]: got %h expected %h", i, dut.memory[i], exp_mem[i]);
            end
        end
        $display("[TB] test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_partial_strobe();
        test_write_disabled();
        test_read_hold();
        test_out_of_range();
        test_collision();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
